// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vga_pkg
//  Purpose  : Shared types and constants for the text-mode VGA path:
//             VRAM read-owner encoding, default VRAM geometry, text grid.
//  Revision : 1.0 - initial release
// ============================================================================
package vga_pkg;

    // Default VRAM shape: 70x30 = 2100 character cells fit in 4K words.
    localparam int DEF_ADDR_W = 12;
    localparam int DEF_DATA_W = 8;

    // Text grid geometry.
    localparam int COLS = 70;
    localparam int ROWS = 30;

    // Who owns the read data returning from VRAM next cycle.
    typedef enum logic [1:0] {
        NONE   = 2'd0,
        VGA    = 2'd1,
        CPU_RD = 2'd2
    } own_t;

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
//  Module   : sat_counter
//  Purpose  : Up-counter that sticks at all-ones instead of wrapping.
//  Ports    : pclk  - clock
//             reset - asynchronous active-high reset (clears count)
//             inc   - count enable
//             count - current value
//  Revision : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             pclk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/vga_vram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : vga_vram_arbiter
//  Purpose  : Shares one synchronous-read character VRAM between the VGA
//             scan fetch (strict priority, fixed 2-cycle latency) and a CPU
//             valid/ready port with a single response register.
//  Ports    : pclk/reset            - pixel clock, async active-high reset
//             vga_req/vga_addr      - scan fetch request
//             vga_vld/vga_data      - scan data, 2 cycles after request
//             cpu_valid/ready/we/addr/wdata - CPU request channel
//             cpu_rsp_valid/ready/rdata     - CPU read response channel
//             mem_en/we/addr/wdata/rdata    - VRAM macro port
//             stall_cnt             - saturating CPU stall-cycle count
//  Revision : 1.0 - initial release
// ============================================================================
module vga_vram_arbiter
    import vga_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = 16
) (
    input  logic              pclk,
    input  logic              reset,
    // Scan side
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_vld,
    output logic [DATA_W-1:0] vga_data,
    // CPU request
    input  logic              cpu_valid,
    output logic              cpu_ready,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    // CPU response
    output logic              cpu_rsp_valid,
    input  logic              cpu_rsp_ready,
    output logic [DATA_W-1:0] cpu_rdata,
    // VRAM port
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    // Statistics
    output logic [CNT_W-1:0]  stall_cnt
);

    own_t              r_own;        // owner of the read issued last cycle
    logic              r_vga_vld;
    logic [DATA_W-1:0] r_vga_data;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rdata;

    own_t              w_own_next;
    logic              w_blocked;

    // ------------------------------------------------------------------
    // Grant. VGA always wins. A CPU read must find the response slot free
    // (or being drained this cycle) and no earlier read still in flight;
    // a CPU write only needs the port, since it produces no response.
    // ------------------------------------------------------------------
    always_comb begin
        w_blocked  = (r_own == CPU_RD) || (r_rsp_valid && !cpu_rsp_ready);
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = cpu_addr;
        mem_wdata  = cpu_wdata;
        cpu_ready  = 1'b0;
        w_own_next = NONE;

        if (vga_req) begin
            mem_en     = 1'b1;
            mem_addr   = vga_addr;
            w_own_next = VGA;
        end else if (cpu_valid && (cpu_we || !w_blocked)) begin
            mem_en     = 1'b1;
            mem_we     = cpu_we;
            cpu_ready  = 1'b1;
            w_own_next = cpu_we ? NONE : CPU_RD;
        end
    end

    // ------------------------------------------------------------------
    // Owner pipeline and read-data capture. mem_rdata belongs to the
    // requester recorded in r_own. A fresh CPU capture takes precedence
    // over a same-edge response drain.
    // ------------------------------------------------------------------
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            r_own       <= NONE;
            r_vga_vld   <= 1'b0;
            r_vga_data  <= '0;
            r_rsp_valid <= 1'b0;
            r_rdata     <= '0;
        end else begin
            r_own     <= w_own_next;
            r_vga_vld <= (r_own == VGA);
            if (r_own == VGA) begin
                r_vga_data <= mem_rdata;
            end
            if (r_own == CPU_RD) begin
                r_rdata     <= mem_rdata;
                r_rsp_valid <= 1'b1;
            end else if (cpu_rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign vga_vld       = r_vga_vld;
    assign vga_data      = r_vga_data;
    assign cpu_rsp_valid = r_rsp_valid;
    assign cpu_rdata     = r_rdata;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .pclk  (pclk),
        .reset (reset),
        .inc   (cpu_valid && !cpu_ready),
        .count (stall_cnt)
    );

endmodule
`default_nettype wire

// File: tb/tb_vga_vram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_vram_arbiter
//  Purpose  : Self-checking bench for vga_vram_arbiter with a behavioural
//             synchronous-read VRAM, a per-cycle vector table and read-data
//             scoreboards for the VGA and CPU response paths.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vga_vram_arbiter;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;

    logic              pclk  = 1'b0;
    logic              reset = 1'b1;
    logic              vga_req;
    logic [ADDR_W-1:0] vga_addr;
    logic              vga_vld;
    logic [DATA_W-1:0] vga_data;
    logic              cpu_valid;
    logic              cpu_ready;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_rsp_valid;
    logic              cpu_rsp_ready;
    logic [DATA_W-1:0] cpu_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic [CNT_W-1:0]  stall_cnt;

    vga_vram_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .pclk          (pclk),
        .reset         (reset),
        .vga_req       (vga_req),
        .vga_addr      (vga_addr),
        .vga_vld       (vga_vld),
        .vga_data      (vga_data),
        .cpu_valid     (cpu_valid),
        .cpu_ready     (cpu_ready),
        .cpu_we        (cpu_we),
        .cpu_addr      (cpu_addr),
        .cpu_wdata     (cpu_wdata),
        .cpu_rsp_valid (cpu_rsp_valid),
        .cpu_rsp_ready (cpu_rsp_ready),
        .cpu_rdata     (cpu_rdata),
        .mem_en        (mem_en),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .stall_cnt     (stall_cnt)
    );

    always #5 pclk = ~pclk;

    // Behavioural VRAM: synchronous read, write at the enable edge.
    logic [DATA_W-1:0] vram [0:4095];
    always @(posedge pclk) begin
        if (mem_en) begin
            if (mem_we) vram[mem_addr] <= mem_wdata;
            else        mem_rdata      <= vram[mem_addr];
        end
    end

    int cyc = 0;
    always @(posedge pclk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp_v);
        end
    endtask

    // Reference contents and scoreboards
    logic [DATA_W-1:0] exp_mem [0:4095];
    typedef struct { int due; logic [DATA_W-1:0] data; } exp_t;
    exp_t vq[$];
    exp_t cq[$];
    int   stall_m = 0;

    typedef struct {
        logic              vreq;
        logic [ADDR_W-1:0] vaddr;
        logic              cval;
        logic              cwe;
        logic [ADDR_W-1:0] caddr;
        logic [DATA_W-1:0] cwd;
        logic              rrdy;
        logic              e_rdy;   // expected cpu_ready
    } vec_t;

    function automatic vec_t mk(input int vr, input int va, input int cv, input int cw,
                                input int ca, input int cd, input int rr, input int er);
        vec_t v;
        v.vreq  = vr[0];
        v.vaddr = va[ADDR_W-1:0];
        v.cval  = cv[0];
        v.cwe   = cw[0];
        v.caddr = ca[ADDR_W-1:0];
        v.cwd   = cd[DATA_W-1:0];
        v.rrdy  = rr[0];
        v.e_rdy = er[0];
        return v;
    endfunction

    // Read-data monitors, sampled mid-cycle.
    always @(negedge pclk) begin
        bit ev;
        bit ec;
        if (!reset) begin
            ev = (vq.size() > 0) && (vq[0].due == cyc);
            chk("vga_vld", 32'(vga_vld), 32'(ev));
            if (ev) begin
                chk("vga_data", 32'(vga_data), 32'(vq[0].data));
                void'(vq.pop_front());
            end
            ec = (cq.size() > 0) && (cq[0].due <= cyc);
            chk("cpu_rsp_valid", 32'(cpu_rsp_valid), 32'(ec));
            if (ec) begin
                chk("cpu_rdata", 32'(cpu_rdata), 32'(cq[0].data));
                if (cpu_rsp_ready) void'(cq.pop_front());
            end
        end
    end

    // Drive one cycle, check the grant, predict read data and stall count.
    task automatic apply(input vec_t v);
        vga_req       = v.vreq;
        vga_addr      = v.vaddr;
        cpu_valid     = v.cval;
        cpu_we        = v.cwe;
        cpu_addr      = v.caddr;
        cpu_wdata     = v.cwd;
        cpu_rsp_ready = v.rrdy;
        #2;
        chk("cpu_ready", 32'(cpu_ready), 32'(v.e_rdy));
        chk("mem_en", 32'(mem_en), 32'(v.vreq | v.e_rdy));
        if (v.vreq) begin
            chk("mem_we_vga", 32'(mem_we), 32'(1'b0));
            chk("mem_addr_vga", 32'(mem_addr), 32'(v.vaddr));
            vq.push_back('{due: cyc + 2, data: exp_mem[v.vaddr]});
        end else if (v.e_rdy) begin
            chk("mem_we_cpu", 32'(mem_we), 32'(v.cwe));
            chk("mem_addr_cpu", 32'(mem_addr), 32'(v.caddr));
            if (v.cwe) begin
                chk("mem_wdata", 32'(mem_wdata), 32'(v.cwd));
                exp_mem[v.caddr] = v.cwd;
            end else begin
                cq.push_back('{due: cyc + 2, data: exp_mem[v.caddr]});
            end
        end
        if (v.cval && !v.e_rdy && stall_m != 15) stall_m++;
        @(posedge pclk);
        #1;
        chk("stall_cnt", 32'(stall_cnt), stall_m);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply(mk(0, 0, 0, 0, 0, 0, 1, 0));
    endtask

    vec_t tbl[$];

    initial begin
        //      vreq vaddr  cval we caddr  wdata rrdy exp_ready
        tbl.push_back(mk(0, 0,     0, 0, 0,     0,    1, 0)); // idle after reset
        tbl.push_back(mk(0, 0,     1, 1, 'h020, 'hC3, 1, 1)); // writes
        tbl.push_back(mk(0, 0,     1, 1, 'h030, 'h3C, 1, 1));
        tbl.push_back(mk(0, 0,     1, 1, 'h010, 'h41, 1, 1));
        tbl.push_back(mk(0, 0,     1, 0, 'h010, 0,    1, 1)); // read accept
        tbl.push_back(mk(0, 0,     1, 0, 'h010, 0,    1, 0)); // read in flight blocks
        tbl.push_back(mk(0, 0,     1, 0, 'h010, 0,    1, 1)); // slot freeing: accept
        tbl.push_back(mk(0, 0,     0, 0, 0,     0,    1, 0));
        tbl.push_back(mk(1, 'h020, 1, 0, 'h030, 0,    1, 0)); // collision: VGA wins
        tbl.push_back(mk(0, 0,     1, 0, 'h030, 0,    1, 1)); // CPU next cycle
        tbl.push_back(mk(0, 0,     0, 0, 0,     0,    1, 0));
        tbl.push_back(mk(0, 0,     0, 0, 0,     0,    1, 0));
        tbl.push_back(mk(0, 0,     1, 1, 'h050, 'h77, 1, 1)); // backpressure setup
        tbl.push_back(mk(0, 0,     1, 1, 'h060, 'h88, 1, 1));
        tbl.push_back(mk(0, 0,     1, 0, 'h050, 0,    0, 1)); // read, rsp not taken
        tbl.push_back(mk(0, 0,     1, 0, 'h060, 0,    0, 0)); // in flight
        tbl.push_back(mk(0, 0,     1, 0, 'h060, 0,    0, 0)); // slot held
        tbl.push_back(mk(0, 0,     1, 1, 'h050, 'h99, 0, 1)); // write still goes
        tbl.push_back(mk(0, 0,     0, 0, 0,     0,    0, 0)); // response held
        tbl.push_back(mk(0, 0,     1, 0, 'h060, 0,    1, 1)); // drain frees slot
        tbl.push_back(mk(0, 0,     0, 0, 0,     0,    1, 0));
        tbl.push_back(mk(0, 0,     0, 0, 0,     0,    1, 0));
        tbl.push_back(mk(1, 'h050, 0, 0, 0,     0,    1, 0)); // sees the 0x99 write
        tbl.push_back(mk(0, 0,     0, 0, 0,     0,    1, 0));
        tbl.push_back(mk(0, 0,     0, 0, 0,     0,    1, 0));

        vga_req = 0; vga_addr = '0; cpu_valid = 0; cpu_we = 0;
        cpu_addr = '0; cpu_wdata = '0; cpu_rsp_ready = 0;

        // Reset state
        repeat (2) @(posedge pclk);
        #1;
        chk("rst_vga_vld", 32'(vga_vld), 0);
        chk("rst_vga_data", 32'(vga_data), 0);
        chk("rst_rsp_valid", 32'(cpu_rsp_valid), 0);
        chk("rst_rdata", 32'(cpu_rdata), 0);
        chk("rst_stall", 32'(stall_cnt), 0);
        chk("rst_mem_en", 32'(mem_en), 0);
        vga_req = 1; vga_addr = 12'h123;
        #2;
        chk("rst_mem_en_vga", 32'(mem_en), 1);
        chk("rst_mem_addr_vga", 32'(mem_addr), 32'h123);
        vga_req = 0;
        @(posedge pclk);
        #1;
        reset = 0;

        foreach (tbl[i]) apply(tbl[i]);

        // Write followed immediately by a VGA read of the same cell
        apply(mk(0, 0,     1, 1, 'h070, 'h12, 1, 1));
        apply(mk(1, 'h070, 0, 0, 0,     0,    1, 0));
        idle(2);

        // Reset one cycle after a CPU read accept: the read is dropped
        apply(mk(0, 0, 1, 0, 'h070, 0, 1, 1));
        reset = 1;
        vq.delete();
        cq.delete();
        stall_m = 0;
        cpu_valid = 0; vga_req = 1; vga_addr = 12'h020;
        #2;
        chk("mid_rst_mem_en", 32'(mem_en), 1);
        chk("mid_rst_rsp_valid", 32'(cpu_rsp_valid), 0);
        chk("mid_rst_vga_vld", 32'(vga_vld), 0);
        chk("mid_rst_vga_data", 32'(vga_data), 0);
        chk("mid_rst_rdata", 32'(cpu_rdata), 0);
        chk("mid_rst_stall", 32'(stall_cnt), 0);
        @(posedge pclk);
        #1;
        reset = 0;
        vga_req = 0;
        idle(3);

        // Starvation, then saturation of the 4-bit stall counter
        for (int i = 0; i < 10; i++)
            apply(mk(1, (i % 2 == 0) ? 'h020 : 'h030, 1, 0, 'h010, 0, 1, 0));
        chk("stall_after_10", 32'(stall_cnt), 10);
        for (int i = 0; i < 8; i++)
            apply(mk(1, (i % 2 == 0) ? 'h030 : 'h020, 1, 0, 'h010, 0, 1, 0));
        chk("stall_saturated", 32'(stall_cnt), 15);
        apply(mk(0, 0, 1, 0, 'h010, 0, 1, 1));
        idle(4);
        chk("scoreboard_drained", 32'(vq.size() + cq.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no end of test, expected finish before 100000 ns");
        $fatal(1);
    end

endmodule
`default_nettype wire
